// File: rtl/buzzer_pkg.sv
// Shared constants for the event buzzer: note half-periods at 50 MHz and the
// sequencer state encoding.
package buzzer_pkg;

    localparam int DO4      = 95_556;
    localparam int RE4      = 85_131;
    localparam int MI4      = 75_843;
    localparam int FA4      = 71_586;
    localparam int SOL4     = 63_776;
    localparam int LA4      = 56_818;
    localparam int SI4      = 50_620;
    localparam int DO5      = 47_778;
    localparam int SILENCIO = 0;

    // The lowest note has the longest half-period and sets the divider width.
    localparam int HP_MAX = DO4;

    typedef enum logic [1:0] {
        IDLE,
        NOTA,
        GAP
    } estado_t;

endpackage

// File: rtl/buzzer_nota_rom.sv
// Constant melody table: half-period of note idx within melody evt.
// An entry of 0 is a rest; unused entries read as 0.
module buzzer_nota_rom
    import buzzer_pkg::*;
#(
    parameter int DIV_W = 20
) (
    input  logic [2:0]       evt,
    input  logic [2:0]       idx,
    output logic [DIV_W-1:0] hp
);

    always_comb begin
        hp = '0;
        case ({evt, idx})
            6'o00: hp = DIV_W'(DO4);
            6'o01: hp = DIV_W'(MI4);
            6'o02: hp = DIV_W'(SOL4);
            6'o03: hp = DIV_W'(DO5);
            6'o10: hp = DIV_W'(SOL4);
            6'o11: hp = DIV_W'(SOL4);
            6'o12: hp = DIV_W'(MI4);
            6'o13: hp = DIV_W'(SILENCIO);
            6'o20: hp = DIV_W'(DO4);
            6'o21: hp = DIV_W'(RE4);
            6'o22: hp = DIV_W'(MI4);
            6'o23: hp = DIV_W'(FA4);
            6'o30: hp = DIV_W'(LA4);
            6'o31: hp = DIV_W'(SILENCIO);
            6'o32: hp = DIV_W'(LA4);
            6'o33: hp = DIV_W'(SILENCIO);
            default: hp = '0;
        endcase
    end

endmodule

// File: rtl/buzzer_secuenciador.sv
// Event-driven melody sequencer for the piezo buzzer: queues event requests by
// priority and plays each melody as a series of note/gap periods.
module buzzer_secuenciador
    import buzzer_pkg::*;
#(
    parameter int N_EVT       = 4,
    parameter int N_NOTAS     = 4,
    parameter int NOTA_CICLOS = 7_500_000,
    parameter int GAP_CICLOS  = 1_000_000,
    parameter int DIV_W       = 20,
    parameter int HP_SHIFT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_EVT-1:0] evt_req,
    input  logic             mute,
    output logic             buzzer,
    output logic             busy,
    output logic [2:0]       evt_actual
);

    localparam int DUR_MAX = (NOTA_CICLOS > GAP_CICLOS) ? NOTA_CICLOS : GAP_CICLOS;
    localparam int DUR_W   = (DUR_MAX > 1) ? $clog2(DUR_MAX) : 1;

    if ((longint'(HP_MAX) >> DIV_W) != 0) begin : g_chk_div_w
        $error("DIV_W too narrow for the longest half-period");
    end
    if (N_EVT < 1 || N_EVT > 8) begin : g_chk_n_evt
        $error("N_EVT must be 1..8");
    end
    if (N_NOTAS < 1 || N_NOTAS > 8) begin : g_chk_n_notas
        $error("N_NOTAS must be 1..8");
    end

    estado_t          state, state_d;
    logic [N_EVT-1:0] pending, pending_d;
    logic [N_EVT-1:0] self_mask, cand;
    logic [2:0]       evt_q, evt_d, idx_q, idx_d, pick;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DIV_W-1:0] hp_rom, hp, tone_cnt, tone_cnt_d;
    logic             tone_q, tone_d, buzzer_q, start, nota_fin, gap_fin;

    buzzer_nota_rom #(.DIV_W(DIV_W)) u_rom (
        .evt (evt_q),
        .idx (idx_q),
        .hp  (hp_rom)
    );

    assign hp         = hp_rom >> HP_SHIFT;
    assign nota_fin   = (dur_q == DUR_W'(NOTA_CICLOS - 1));
    assign gap_fin    = (dur_q == DUR_W'(GAP_CICLOS - 1));
    assign busy       = (state != IDLE);
    assign evt_actual = evt_q;
    assign buzzer     = buzzer_q;

    // The melody being played cannot re-request itself; the lowest index wins.
    always_comb begin
        self_mask = '0;
        pick      = '0;
        for (int i = 0; i < N_EVT; i++) begin
            if (busy && evt_q == 3'(i)) self_mask[i] = 1'b1;
        end
        cand = pending | (evt_req & ~self_mask);
        for (int i = N_EVT - 1; i >= 0; i--) begin
            if (cand[i]) pick = 3'(i);
        end
    end

    always_comb begin
        state_d   = state;
        pending_d = cand;
        evt_d     = evt_q;
        idx_d     = idx_q;
        dur_d     = dur_q + 1'b1;
        start     = 1'b0;
        case (state)
            IDLE: begin
                dur_d = '0;
                start = (cand != '0);
            end
            NOTA: begin
                if (nota_fin) begin
                    state_d = GAP;
                    dur_d   = '0;
                end
            end
            GAP: begin
                if (gap_fin) begin
                    dur_d = '0;
                    if (idx_q == 3'(N_NOTAS - 1)) begin
                        state_d = IDLE;
                        start   = (cand != '0);
                    end else begin
                        state_d = NOTA;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A queued melody starts on the same edge the previous one finishes.
        if (start) begin
            state_d = NOTA;
            evt_d   = pick;
            idx_d   = '0;
            for (int i = 0; i < N_EVT; i++) begin
                if (pick == 3'(i)) pending_d[i] = 1'b0;
            end
        end
    end

    // Tone divider only runs while staying inside the same note; any other
    // transition clears it so each note starts low.
    always_comb begin
        tone_cnt_d = '0;
        tone_d     = 1'b0;
        if (state == NOTA && !nota_fin) begin
            tone_cnt_d = tone_cnt;
            tone_d     = tone_q;
            if (hp != '0) begin
                if (tone_cnt == hp - 1'b1) begin
                    tone_cnt_d = '0;
                    tone_d     = ~tone_q;
                end else begin
                    tone_cnt_d = tone_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pending  <= '0;
            evt_q    <= '0;
            idx_q    <= '0;
            dur_q    <= '0;
            tone_cnt <= '0;
            tone_q   <= 1'b0;
            buzzer_q <= 1'b0;
        end else begin
            state    <= state_d;
            pending  <= pending_d;
            evt_q    <= evt_d;
            idx_q    <= idx_d;
            dur_q    <= dur_d;
            tone_cnt <= tone_cnt_d;
            tone_q   <= tone_d;
            buzzer_q <= tone_d & ~mute;
        end
    end

endmodule

// File: tb/tb_buzzer_secuenciador.sv
// Randomised scoreboard bench for buzzer_secuenciador with shortened note
// timing; the reference model derives outputs from elapsed time in a melody.
module tb_buzzer_secuenciador;

    localparam int N_EVT   = 4;
    localparam int N_NOTAS = 4;
    localparam int NOTA    = 300;
    localparam int GAP     = 40;
    localparam int DIV_W   = 20;
    localparam int SHIFT   = 10;
    localparam int PER     = NOTA + GAP;
    localparam int LEN     = N_NOTAS * PER;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] evt_req = 4'b0;
    logic       mute = 1'b0;
    logic       buzzer, busy;
    logic [2:0] evt_actual;

    always #5 clk = ~clk;

    buzzer_secuenciador #(
        .N_EVT(N_EVT), .N_NOTAS(N_NOTAS), .NOTA_CICLOS(NOTA),
        .GAP_CICLOS(GAP), .DIV_W(DIV_W), .HP_SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .evt_req(evt_req), .mute(mute),
        .buzzer(buzzer), .busy(busy), .evt_actual(evt_actual)
    );

    typedef struct packed {
        logic       busy;
        logic [2:0] evt;
        logic       buzzer;
    } obs_t;

    obs_t expq[$];
    int vectors = 0;
    int miscompares = 0;
    longint cyc = 0;

    int melodias [4][4] = '{
        '{95_556, 75_843, 63_776, 47_778},
        '{63_776, 63_776, 75_843, 0},
        '{95_556, 85_131, 75_843, 71_586},
        '{56_818, 0, 56_818, 0}
    };

    bit     m_on = 0;
    bit     m_play = 0;
    int     m_pend = 0;
    int     m_cur = 0;
    longint m_t0 = 0;
    int     req, cand;
    longint e, w;
    int     n, hp;
    obs_t   exp_o;

    // Reference: a melody occupies LEN cycles from its start edge; the buzzer
    // level follows from the offset inside the current note.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_on = 1; m_play = 0; m_pend = 0; m_cur = 0;
        end else if (m_on) begin
            req = int'(evt_req);
            if (m_play) req = req & ~(1 << m_cur);
            if (m_play && (cyc - m_t0) == LEN) m_play = 0;
            cand = m_pend | req;
            if (!m_play && cand != 0) begin
                for (int i = 0; i < N_EVT; i++) begin
                    if (cand[i]) begin
                        m_cur = i;
                        break;
                    end
                end
                m_play = 1;
                m_t0   = cyc;
                m_pend = cand & ~(1 << m_cur);
            end else begin
                m_pend = cand;
            end
        end
        if (m_on) begin
            exp_o.busy   = m_play;
            exp_o.evt    = 3'(m_cur);
            exp_o.buzzer = 1'b0;
            if (m_play) begin
                e  = cyc - m_t0;
                n  = int'(e / PER);
                w  = e % PER;
                hp = melodias[m_cur][n] >> SHIFT;
                if (w < NOTA && hp > 0 && ((w / hp) % 2) == 1 && !mute)
                    exp_o.buzzer = 1'b1;
            end
            expq.push_back(exp_o);
        end
    end

    task automatic check_output(input obs_t want);
        obs_t got;
        got = '{busy: busy, evt: evt_actual, buzzer: buzzer};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL outputs cycle %0d: busy/evt/buzzer got %0b/%0d/%0b expected %0b/%0d/%0b",
                     cyc, got.busy, got.evt, got.buzzer, want.busy, want.evt, want.buzzer);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) check_output(expq.pop_front());
    end

    task automatic wait_cycles(input int n_cyc);
        repeat (n_cyc) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [3:0] r, input int idle);
        @(negedge clk);
        evt_req = r;
        @(negedge clk);
        evt_req = 4'b0;
        wait_cycles(idle);
    endtask

    initial begin
        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(200);

        apply_stimulus(4'b0001, LEN + 20);
        apply_stimulus(4'b0110, 2 * LEN + 20);

        // Alarm melody with mute over note 0
        apply_stimulus(4'b1000, 50);
        mute = 1'b1;
        wait_cycles(300);
        mute = 1'b0;
        wait_cycles(LEN);

        // Self-retrigger attempt while melody 1 plays
        apply_stimulus(4'b0010, 500);
        apply_stimulus(4'b0010, LEN);

        // Reset mid-note of melody 2 with melody 0 pending
        apply_stimulus(4'b0100, 400);
        apply_stimulus(4'b0001, 100);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_cycles(LEN + 50);

        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            evt_req = ($urandom_range(0, 199) == 0) ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 399) == 0) mute = ~mute;
            rst = ($urandom_range(0, 4999) == 0);
        end
        @(negedge clk);
        evt_req = 4'b0;
        rst = 1'b0;
        mute = 1'b0;
        wait_cycles(2 * LEN + 50);

        vectors++;
        if (expq.size() > 1) begin
            miscompares++;
            $display("[TB] FAIL drain: queue holds %0d entries, expected at most 1", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/buzzer_secuenciador.md
Name: buzzer_secuenciador

Overview:
- Parametrised successor to the single-tone button buzzer.
- Plays a short multi-note melody on the piezo buzzer when a game event is requested: reset, feed, play, alarm, …
- Each event selects its own melody from a constant note table.
- Pending requests are queued by priority.
- Sits between the game FSM (which issues one-cycle event pulses) and the buzzer pin.

Parameters:
- N_EVT, 4, number of event channels (1..8).
- N_NOTAS, 4, notes per melody (1..8).
- NOTA_CICLOS, 7_500_000, clk cycles each note sounds (150 ms at 50 MHz).
- GAP_CICLOS, 1_000_000, silent cycles after each note (20 ms at 50 MHz).
- DIV_W, 20, width of tone half-period counter.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- evt_req  in  N_EVT  one-cycle request pulses; bit i requests melody i.
- mute  in  1  level; forces buzzer low, sequencing continues.
- buzzer  out  1  square-wave drive to the piezo.
- busy  out  1  high while a melody (note or gap) is in progress.
- evt_actual  out  3  index of the melody playing; valid while busy.

Behaviour:
- Reset (rst=1 at a clk edge, any state, mid-melody included):
  - buzzer=0, busy=0, evt_actual=0.
  - pending mask cleared; all counters 0; FSM to IDLE.
  - rst takes priority over a same-cycle evt_req; that request is lost.
- Pending mask:
  - Every cycle, pending |= evt_req.
  - The request bit for the melody currently playing is ignored (no self-retrigger).
- FSM states:
  - IDLE: if pending≠0, pick the lowest set index i (lowest index = highest priority). Clear pending[i], evt_actual=i, note index=0, load duration counter, go to NOTA. busy rises the cycle after the request is sampled.
  - NOTA: duration counter counts NOTA_CICLOS. On expiry, go to GAP.
  - GAP: counts GAP_CICLOS with buzzer=0. On expiry:
    - if note index==N_NOTAS-1, go to IDLE (busy falls that edge);
    - else increment note index and go to NOTA.
  - IDLE→NOTA is immediate when pending is still set, so back-to-back melodies have no extra idle cycle.
- Tone generation:
  - Half-period hp is read from the ROM for (evt_actual, note index).
  - In NOTA: tone counter counts 0..hp-1, then wraps to 0 and toggles the internal tone bit.
  - Tone bit and tone counter reset to 0 on every NOTA entry, so each note starts low with its first rising edge hp cycles after entry.
  - hp==0 means a rest: buzzer stays 0 for the note duration.
- Output gating: buzzer = tone bit only when state==NOTA and mute==0; otherwise 0. Registered output, no combinational path from inputs.
- Preemption: none. A higher-priority request waits for the current melody to finish.
- Widths:
  - Duration counter is sized by $clog2 of max(NOTA_CICLOS, GAP_CICLOS).
  - hp must be < 2**DIV_W; elaboration check fails otherwise.

Decomposition:
- Package buzzer_pkg holds:
  - note half-period constants at 50 MHz: DO4=95_556, RE4=85_131, MI4=75_843, FA4=71_586, SOL4=63_776, LA4=56_818, SI4=50_620, DO5=47_778, SILENCIO=0;
  - FSM state encoding (IDLE, NOTA, GAP).
- One sub-module, buzzer_nota_rom: combinational case on {evt, idx} returning hp. Default melodies:
  - evt0 reset: DO4, MI4, SOL4, DO5.
  - evt1 feed: SOL4, SOL4, MI4, SILENCIO.
  - evt2 play: DO4, RE4, MI4, FA4.
  - evt3 alarm: LA4, SILENCIO, LA4, SILENCIO.
  - Unused entries return 0.

Test Plan:
- rst held 3 cycles then released, no requests → buzzer=0, busy=0 for 1_000_000 cycles.
- evt_req=4'b0001 pulse at cycle T → busy=1 at T+1. First buzzer rise 95_556 cycles after NOTA entry. busy falls after exactly 4×(7_500_000+1_000_000) cycles.
- evt_req=4'b0110 in one cycle → melody 2 is skipped in favour of melody 1 (evt_actual=1). Melody 2 starts on the cycle melody 1 ends; no idle gap.
- Melody 3 playing; mute=1 during note 0 → buzzer=0 throughout, busy and note timing unchanged. Notes 1 and 3 (rests) are silent regardless of mute.
- evt_req=4'b0010 while melody 1 plays → ignored; busy falls after one melody length.
- rst asserted mid-note of melody 2 with pending bit 0 set → next cycle buzzer=0, busy=0, IDLE. Pending is cleared, so no melody starts afterwards.
